instruction_buffer: RTL and testbench



---
 rtl/core_pkg.sv | 10 +
 rtl/instruction_buffer.sv | 93 +++++++++
 tb/tb_instruction_buffer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the front-end pipeline blocks.
//   instr_t   - one 32-bit instruction word
//   NOP_INSTR - canonical no-op (addi x0,x0,0), used by decode for bubbles
package core_pkg;

  typedef logic [31:0] instr_t;

  localparam instr_t NOP_INSTR = 32'h0000_0013;

endpackage : core_pkg

// File: rtl/instruction_buffer.sv
// instruction_buffer: circular queue between fetch and decode.
//   Accepts 0-2 instructions per cycle (A older than B) and presents the two
//   oldest entries to decode as show-ahead outputs. Decode retires 0-2 per
//   cycle. A branch redirect (flush) empties the queue.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   flush                  - branch redirect, empties the buffer
//   instructionA/B(_valid) - fetched instructions, A is older
//   stall                  - fewer than 2 free entries (from registered count)
//   decodeA/B(_valid)      - head and head+1 entries, zero when invalid
//   deqCount               - entries consumed by decode (3 behaves as 2)
module instruction_buffer
  import core_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  instr_t      instructionA,
  input  instr_t      instructionB,
  input  logic        instructionA_valid,
  input  logic        instructionB_valid,
  output logic        stall,
  output instr_t      decodeA,
  output instr_t      decodeB,
  output logic        decodeA_valid,
  output logic        decodeB_valid,
  input  logic [1:0]  deqCount
);

  localparam int PW = $clog2(DEPTH);

  instr_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW:0]     count_q, count_d;

  logic [1:0]      enq;
  logic [1:0]      deq_req;
  logic [1:0]      deq;
  logic [1:0]      enq_eff;
  logic [PW:0]     space;
  instr_t          first_data;
  logic [PW-1:0]   head_p1;
  logic [PW-1:0]   tail_p1;

  always_comb begin
    enq     = {1'b0, instructionA_valid} + {1'b0, instructionB_valid};
    deq_req = (deqCount == 2'd3) ? 2'd2 : deqCount;
    // Never retire more than is held; count_q is below 2 here, so it fits.
    deq     = (count_q < (PW+1)'(deq_req)) ? count_q[1:0] : deq_req;
    // Free slots after this cycle's dequeue; younger words beyond it are dropped.
    space   = (PW+1)'(DEPTH) - count_q + (PW+1)'(deq);
    enq_eff = ((PW+1)'(enq) > space) ? space[1:0] : enq;

    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(enq_eff);
    count_d = count_q + (PW+1)'(enq_eff) - (PW+1)'(deq);

    // The first free slot takes A when present, otherwise B.
    first_data = instructionA_valid ? instructionA : instructionB;
    head_p1    = head_q + PW'(1);
    tail_p1    = tail_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (enq_eff != 2'd0) mem_q[tail_q]  <= first_data;
      if (enq_eff == 2'd2) mem_q[tail_p1] <= instructionB;
    end
  end

  assign stall         = (count_q > (PW+1)'(DEPTH - 2));
  assign decodeA_valid = (count_q != '0) && !flush;
  assign decodeB_valid = (count_q >= (PW+1)'(2)) && !flush;
  assign decodeA       = decodeA_valid ? mem_q[head_q]  : '0;
  assign decodeB       = decodeB_valid ? mem_q[head_p1] : '0;

endmodule : instruction_buffer

// File: tb/tb_instruction_buffer.sv
module tb_instruction_buffer;
  import core_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset, flush;
  instr_t     instructionA, instructionB;
  logic       instructionA_valid, instructionB_valid;
  logic       stall;
  instr_t     decodeA, decodeB;
  logic       decodeA_valid, decodeB_valid;
  logic [1:0] deqCount;

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue of outstanding instructions plus slot indices.
  instr_t mq[$];
  int     mhead = 0;
  int     mtail = 0;

  instruction_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .instructionA(instructionA), .instructionB(instructionB),
    .instructionA_valid(instructionA_valid), .instructionB_valid(instructionB_valid),
    .stall(stall), .decodeA(decodeA), .decodeB(decodeB),
    .decodeA_valid(decodeA_valid), .decodeB_valid(decodeB_valid),
    .deqCount(deqCount)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic idle();
    flush = 0; instructionA_valid = 0; instructionB_valid = 0;
    instructionA = '0; instructionB = '0; deqCount = 0;
  endtask

  task automatic model_push(input instr_t d, inout bit ovf);
    if (mq.size() < DEPTH) begin
      mq.push_back(d);
      mtail = (mtail + 1) % DEPTH;
    end else begin
      ovf = 1;
    end
  endtask

  // Advance one clock edge and update the model from the inputs seen at it.
  task automatic step();
    int d;
    bit ovf;
    @(posedge clk);
    ovf = 0;
    if (reset || flush) begin
      mq.delete(); mhead = 0; mtail = 0;
    end else begin
      d = (deqCount == 3) ? 2 : int'(deqCount);
      if (d > mq.size()) d = mq.size();
      repeat (d) void'(mq.pop_front());
      mhead = (mhead + d) % DEPTH;
      if (instructionA_valid) model_push(instructionA, ovf);
      if (instructionB_valid) model_push(instructionB, ovf);
    end
    tests++;
    if (ovf) begin
      fails++;
      $display("FAIL overflow: enqueue beyond capacity, model size %0d required <= %0d", mq.size(), DEPTH);
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; step(); step(); reset = 0;
  endtask

  task automatic enq_pair(input instr_t a, input instr_t b);
    instructionA = a; instructionB = b;
    instructionA_valid = 1; instructionB_valid = 1; deqCount = 0;
    step(); idle();
  endtask

  task automatic enq_single(input instr_t a);
    instructionA = a; instructionA_valid = 1; instructionB_valid = 0; deqCount = 0;
    step(); idle();
  endtask

  task automatic test_reset();
    do_reset(); #1;
    tests++;
    if (decodeA !== 32'h0 || decodeB !== 32'h0 || decodeA_valid !== 1'b0 ||
        decodeB_valid !== 1'b0 || stall !== 1'b0 || dut.count_q !== '0) begin
      fails++;
      $display("FAIL reset_state: A=%h B=%h av=%b bv=%b stall=%b count=%0d required all zero",
               decodeA, decodeB, decodeA_valid, decodeB_valid, stall, dut.count_q);
    end
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_fill();
    do_reset();
    enq_pair(32'h11, 32'h22); #1;
    tests++;
    if (decodeA !== 32'h11 || decodeB !== 32'h22 || decodeA_valid !== 1 ||
        decodeB_valid !== 1 || dut.count_q !== 2 || stall !== 0) begin
      fails++;
      $display("FAIL first_pair: A=%h B=%h av=%b bv=%b count=%0d stall=%b required 11 22 1 1 2 0",
               decodeA, decodeB, decodeA_valid, decodeB_valid, dut.count_q, stall);
    end
    for (int i = 2; i <= 4; i++) begin
      enq_pair(instr_t'(32'h100 + i), instr_t'(32'h200 + i)); #1;
      tests++;
      if (stall !== (i == 4) || dut.count_q !== 2 * i) begin
        fails++;
        $display("FAIL fill_stall edge %0d: stall=%b count=%0d required stall=%b count=%0d",
                 i, stall, dut.count_q, (i == 4), 2 * i);
      end
    end
    $display("[TB] fill: count=%0d stall=%b", dut.count_q, stall);
  endtask

  task automatic test_wrap();
    int slot_a, slot_b;
    do_reset();
    for (int i = 0; i < 3; i++) enq_pair(instr_t'(i), instr_t'(i + 10));
    enq_single(32'h77);
    for (int i = 0; i < 4; i++) begin
      deqCount = (i == 3) ? 2'd1 : 2'd2; step(); idle();
    end
    slot_a = mtail; slot_b = (mtail + 1) % DEPTH;
    enq_pair(32'hA, 32'hB); #1;
    tests++;
    if (slot_a != 7 || dut.mem_q[slot_a] !== 32'hA || dut.mem_q[slot_b] !== 32'hB) begin
      fails++;
      $display("FAIL wrap_slots: slot%0d=%h slot%0d=%h required slot7=0000000a slot0=0000000b",
               slot_a, dut.mem_q[slot_a], slot_b, dut.mem_q[slot_b]);
    end
    tests++;
    if (decodeA !== 32'hA || decodeB !== 32'hB || decodeA_valid !== 1 || decodeB_valid !== 1) begin
      fails++;
      $display("FAIL wrap_decode: A=%h B=%h av=%b bv=%b required a b 1 1",
               decodeA, decodeB, decodeA_valid, decodeB_valid);
    end
    $display("[TB] wrap: A=%h B=%h", decodeA, decodeB);
  endtask

  task automatic test_flush();
    do_reset();
    enq_pair(32'h1, 32'h2); enq_pair(32'h3, 32'h4); enq_single(32'h5);
    flush = 1; instructionA = 32'h66; instructionB = 32'h67;
    instructionA_valid = 1; instructionB_valid = 1; deqCount = 2; #1;
    tests++;
    if (decodeA_valid !== 0 || decodeB_valid !== 0 || dut.count_q !== 5) begin
      fails++;
      $display("FAIL flush_cycle: av=%b bv=%b count=%0d required 0 0 5",
               decodeA_valid, decodeB_valid, dut.count_q);
    end
    step(); idle(); #1;
    tests++;
    if (dut.count_q !== 0 || decodeA_valid !== 0 || decodeB_valid !== 0 || stall !== 0) begin
      fails++;
      $display("FAIL flush_after: count=%0d av=%b bv=%b stall=%b required 0 0 0 0",
               dut.count_q, decodeA_valid, decodeB_valid, stall);
    end
    $display("[TB] flush: count=%0d", dut.count_q);
  endtask

  task automatic test_single_overdeq();
    do_reset();
    enq_single(32'h44);
    instructionB = 32'h33; instructionB_valid = 1; instructionA_valid = 0; deqCount = 2;
    step(); idle(); #1;
    tests++;
    if (decodeA !== 32'h33 || decodeA_valid !== 1 || decodeB_valid !== 0 ||
        decodeB !== 32'h0 || dut.count_q !== 1) begin
      fails++;
      $display("FAIL single_overdeq: A=%h av=%b bv=%b B=%h count=%0d required 33 1 0 0 1",
               decodeA, decodeA_valid, decodeB_valid, decodeB, dut.count_q);
    end
    $display("[TB] single/over-dequeue: A=%h", decodeA);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) enq_pair(instr_t'(i + 1), instr_t'(i + 20));
    enq_single(32'h99); #1;
    tests++;
    if (stall !== 1 || dut.count_q !== 7) begin
      fails++;
      $display("FAIL pre_reset: stall=%b count=%0d required 1 7", stall, dut.count_q);
    end
    reset = 1; instructionA = 32'h55; instructionA_valid = 1; instructionB_valid = 0;
    step(); reset = 0; idle(); #1;
    tests++;
    if (dut.count_q !== 0 || stall !== 0 || decodeA_valid !== 0 || decodeB_valid !== 0 ||
        decodeA !== 0 || decodeB !== 0) begin
      fails++;
      $display("FAIL reset_mid: count=%0d stall=%b av=%b bv=%b A=%h B=%h required all zero",
               dut.count_q, stall, decodeA_valid, decodeB_valid, decodeA, decodeB);
    end
    $display("[TB] reset mid-operation: count=%0d", dut.count_q);
  endtask

  task automatic test_random();
    instr_t ea, eb;
    bit eav, ebv, est;
    int errs = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(0, 19) == 0);
      if (mq.size() > DEPTH - 2) begin
        instructionA_valid = 0; instructionB_valid = 0;
      end else begin
        instructionA_valid = 1'($urandom); instructionB_valid = 1'($urandom);
      end
      instructionA = $urandom; instructionB = $urandom;
      deqCount = 2'($urandom_range(0, 3));
      step(); idle(); #1;
      eav = mq.size() >= 1; ebv = mq.size() >= 2;
      ea  = eav ? mq[0] : 32'h0;
      eb  = ebv ? mq[1] : 32'h0;
      est = mq.size() > DEPTH - 2;
      tests++;
      if (decodeA !== ea || decodeB !== eb || decodeA_valid !== eav ||
          decodeB_valid !== ebv || stall !== est) begin
        fails++; errs++;
        $display("FAIL random cycle %0d: A=%h B=%h av=%b bv=%b stall=%b required %h %h %b %b %b",
                 n, decodeA, decodeB, decodeA_valid, decodeB_valid, stall, ea, eb, eav, ebv, est);
      end
    end
    $display("[TB] random: 400 cycles, %0d mismatching cycles", errs);
  endtask

  initial begin
    idle(); reset = 1;
    test_reset();
    test_fill();
    test_wrap();
    test_flush();
    test_single_overdeq();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_instruction_buffer
